mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 4, cycles from request accept to first response (legal range 1..15).
REQ-002 SHALL have parameter BLOCK_WORDS, default 4, words per cache-line refill.
REQ-003 SHALL have parameter DEPTH_WORDS, default 256, 32-bit words of backing storage.
REQ-004 SHALL have clk  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have req_read  in  1  line-refill request from cache controller, held until done.
REQ-007 SHALL have req_write  in  1  write-through request, held until done.
REQ-008 SHALL have address  in  10  byte address: [9:7] tag, [9:4] block base, [9:2] word.
REQ-009 SHALL have wdata  in  32  write-through data.
REQ-010 SHALL have rdata  out  32  refill beat data.
REQ-011 SHALL have rdata_valid  out  1  rdata is a valid beat this cycle.
REQ-012 SHALL have beat_idx  out  2  word offset of current beat within block.
REQ-013 SHALL have done  out  1  one-cycle pulse, transaction complete.
REQ-014 SHALL have busy  out  1  high in every state except IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, BURST, WRITE, REST.
REQ-016 SHALL accept a request only in IDLE; accept edge = first rising edge with req_read or req_write high in IDLE.
REQ-017 SHALL give req_read priority when both requests are high at accept.
REQ-018 SHALL latch address and wdata at accept; input changes after accept are ignored until REST.
REQ-019 Read: IDLE->WAIT; first rdata_valid exactly LATENCY cycles after accept edge (LATENCY=1: cycle immediately after accept).
REQ-020 Read: WAIT->BURST; BLOCK_WORDS consecutive beats, beat_idx 0,1,2,3, word address {block base, beat_idx}; no critical-word-first.
REQ-021 Read: done SHALL assert in the same cycle as the last beat (beat_idx=3), then state->REST.
REQ-022 Write: IDLE->WRITE; storage word address[9:2] updated with latched wdata at the edge ending cycle LATENCY after accept; done high in that cycle; then ->REST.
REQ-023 SHALL ignore address[1:0] for both reads and writes.
REQ-024 REST SHALL last exactly one cycle with busy high and done low, then ->IDLE; a request still high in IDLE is a new transaction.
REQ-025 rdata_valid, done, beat_idx SHALL be 0 outside their defined cycles; rdata SHALL be 0 when rdata_valid is low.
REQ-026 Latency counter SHALL be 4 bits, load LATENCY-1 at accept, decrement to 0, never wrap.
REQ-027 Request deassertion mid-transaction SHALL NOT abort it; transaction completes normally.

Reset
REQ-028 rst high SHALL immediately force state IDLE, counter 0, beat index 0, and rdata=0, rdata_valid=0, beat_idx=0, done=0, busy=0.
REQ-029 Reset mid-transaction SHALL abandon it without done; a pending write not yet committed SHALL NOT modify storage.
REQ-030 Storage contents SHALL NOT be cleared by reset.

Structure
REQ-031 Shared package cache_pkg SHALL hold ADDR_W=10, DATA_W=32, BLOCK_WORDS, tag/index bit-position constants and typedef enum mem_state_t.
REQ-032 Storage SHALL be sub-module mem_array: DEPTH_WORDS x 32, single port, synchronous write, combinational read.

Verification
REQ-033 Reset, then req_read, address=0x0A4 accepted at cycle 0 -> rdata_valid cycles 4..7, words 0x28..0x2B, done at cycle 7, busy low at cycle 9.
REQ-034 req_write, address=0x013, wdata=0xDEADBEEF -> done at cycle 4, word 0x04 = 0xDEADBEEF; subsequent read of 0x010 returns it on beat_idx 0.
REQ-035 req_read and req_write both high at accept -> read burst performed, storage unchanged.
REQ-036 rst pulsed at cycle 2 of a write to 0x020 -> all outputs 0 immediately, no done, word 0x08 unchanged.
REQ-037 LATENCY=1, req_read held through done -> beats cycles 1..4, REST cycle 5, second read accepted cycle 6.
REQ-038 address and wdata changed one cycle after write accept -> originally latched values committed.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and address-field constants for the cache refill responder.
// Holds bus widths, block geometry, address bit positions and FSM states.
package cache_pkg;

   localparam int ADDR_W      = 10;
   localparam int DATA_W      = 32;
   localparam int BLOCK_WORDS = 4;

   // Byte address fields: [9:7] tag, [9:4] block base, [9:2] word.
   localparam int TAG_MSB  = 9;
   localparam int TAG_LSB  = 7;
   localparam int BLK_MSB  = 9;
   localparam int BLK_LSB  = 4;
   localparam int WORD_MSB = 9;
   localparam int WORD_LSB = 2;
   localparam int WORD_W   = WORD_MSB - WORD_LSB + 1;
   localparam int BEAT_W   = 2;

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      BURST,
      WRITE,
      REST
   } mem_state_t;

endpackage

// File: rtl/mem_responder_mem_array.sv
// Backing store: DEPTH_WORDS x 32, one shared address port.
// Ports: clk_i, we_i, addr_i, wdata_i (sync write); rdata_o (comb read).
import cache_pkg::*;

module mem_array #(
   parameter int DEPTH_WORDS = 256,
   parameter int AW          = WORD_W
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [AW-1:0]     addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

   // No reset: contents survive rst.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for a cache: block refills and write-through.
// Ports: clk, rst (async high); req_read/req_write, address, wdata in;
// rdata, rdata_valid, beat_idx, done (one-cycle), busy out.
import cache_pkg::*;

module mem_responder #(
   parameter int LATENCY     = 4,
   parameter int BLOCK_WORDS = cache_pkg::BLOCK_WORDS,
   parameter int DEPTH_WORDS = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_read,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              rdata_valid,
   output logic [1:0]        beat_idx,
   output logic              done,
   output logic              busy
);

   localparam logic [3:0]        LAT_LOAD  = 4'(LATENCY - 1);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLOCK_WORDS - 1);

   mem_state_t        state_q;
   logic [3:0]        cnt_q;
   logic [BEAT_W-1:0] beat_q;
   logic [BEAT_W-1:0] beat_d;
   logic [WORD_W-1:0] waddr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic              valid_q;
   logic              done_q;

   logic [WORD_W-1:0] maddr;
   logic [DATA_W-1:0] mem_rd;
   logic              mem_we;
   logic              unused_addr;

   assign unused_addr = ^address[WORD_LSB-1:0];

   // The single port reads one cycle ahead of each beat, because
   // rdata is registered; in WRITE it points at the latched word.
   always_comb begin
      beat_d = beat_q + 1'b1;
      maddr  = waddr_q;
      unique case (state_q)
         IDLE:    maddr = {address[BLK_MSB:BLK_LSB], 2'd0};
         WAIT:    maddr = {waddr_q[WORD_W-1:BEAT_W], 2'd0};
         BURST:   maddr = {waddr_q[WORD_W-1:BEAT_W], beat_d};
         default: maddr = waddr_q;
      endcase
   end

   // Commit only in the final WRITE cycle; an async reset before then
   // leaves the state machine in IDLE and storage untouched.
   assign mem_we = (state_q == WRITE) && (cnt_q == 4'd0);

   mem_array #(
      .DEPTH_WORDS(DEPTH_WORDS),
      .AW         (WORD_W)
   ) u_mem (
      .clk_i  (clk),
      .we_i   (mem_we),
      .addr_i (maddr),
      .wdata_i(wdata_q),
      .rdata_o(mem_rd)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         beat_q  <= '0;
         waddr_q <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         rdata_q <= '0;
         unique case (state_q)
            IDLE: begin
               if (req_read || req_write) begin
                  waddr_q <= address[WORD_MSB:WORD_LSB];
                  wdata_q <= wdata;
                  cnt_q   <= LAT_LOAD;
               end
               if (req_read) begin
                  // LATENCY=1: first beat lands right after accept.
                  if (LAT_LOAD == 4'd0) begin
                     state_q <= BURST;
                     valid_q <= 1'b1;
                     rdata_q <= mem_rd;
                     done_q  <= (LAST_BEAT == '0);
                  end else begin
                     state_q <= WAIT;
                  end
               end else if (req_write) begin
                  state_q <= WRITE;
                  done_q  <= (LAT_LOAD == 4'd0);
               end
            end
            WAIT: begin
               cnt_q <= cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_q <= BURST;
                  valid_q <= 1'b1;
                  rdata_q <= mem_rd;
                  done_q  <= (LAST_BEAT == '0);
               end
            end
            BURST: begin
               if (beat_q == LAST_BEAT) begin
                  state_q <= REST;
                  beat_q  <= '0;
               end else begin
                  beat_q  <= beat_d;
                  valid_q <= 1'b1;
                  rdata_q <= mem_rd;
                  done_q  <= (beat_d == LAST_BEAT);
               end
            end
            WRITE: begin
               if (cnt_q == 4'd0) begin
                  state_q <= REST;
               end else begin
                  cnt_q  <= cnt_q - 4'd1;
                  done_q <= (cnt_q == 4'd1);
               end
            end
            REST:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rdata       = rdata_q;
   assign rdata_valid = valid_q;
   assign beat_idx    = beat_q;
   assign done        = done_q;
   assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: LATENCY=4 and LATENCY=1 instances.
// Expected beats/done are queued at accept and popped on DUT output.
module tb_mem_responder;

   typedef struct {
      int          ec;
      logic        valid;
      logic [31:0] data;
      logic [1:0]  idx;
      logic        done;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        req_rd [2];
   logic        req_wr [2];
   logic [9:0]  addr   [2];
   logic [31:0] wdat   [2];
   logic [31:0] rdata  [2];
   logic        rvalid [2];
   logic [1:0]  bidx   [2];
   logic        done   [2];
   logic        busy   [2];

   logic [31:0] model [2][256];
   exp_t        q0 [$];
   exp_t        q1 [$];
   int          ec = 0;
   bit          mon_en = 0;
   int          n_chk = 0;
   int          n_pass = 0;

   mem_responder #(
      .LATENCY    (4),
      .BLOCK_WORDS(4),
      .DEPTH_WORDS(256)
   ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .req_read   (req_rd[0]),
      .req_write  (req_wr[0]),
      .address    (addr[0]),
      .wdata      (wdat[0]),
      .rdata      (rdata[0]),
      .rdata_valid(rvalid[0]),
      .beat_idx   (bidx[0]),
      .done       (done[0]),
      .busy       (busy[0])
   );

   mem_responder #(
      .LATENCY    (1),
      .BLOCK_WORDS(4),
      .DEPTH_WORDS(256)
   ) u_dut1 (
      .clk        (clk),
      .rst        (rst),
      .req_read   (req_rd[1]),
      .req_write  (req_wr[1]),
      .address    (addr[1]),
      .wdata      (wdat[1]),
      .rdata      (rdata[1]),
      .rdata_valid(rvalid[1]),
      .beat_idx   (bidx[1]),
      .done       (done[1]),
      .busy       (busy[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) ec <= ec + 1;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic void push(input int u, input exp_t e);
      if (u == 0) q0.push_back(e);
      else q1.push_back(e);
   endfunction

   task automatic mon(input int u);
      exp_t e;
      bit   empty;
      if (rvalid[u] || done[u]) begin
         empty = (u == 0) ? (q0.size() == 0) : (q1.size() == 0);
         if (empty) begin
            check("spurious_out", 32'(rvalid[u] | done[u]), 0);
         end else begin
            if (u == 0) e = q0.pop_front();
            else e = q1.pop_front();
            check("beat_cycle", 32'(ec), 32'(e.ec));
            check("rvalid", 32'(rvalid[u]), 32'(e.valid));
            check("rdata", rdata[u], e.data);
            check("beat_idx", 32'(bidx[u]), 32'(e.idx));
            check("done", 32'(done[u]), 32'(e.done));
         end
      end else begin
         check("quiet", rdata[u] | 32'(bidx[u]), 0);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         for (int u = 0; u < 2; u++) mon(u);
      end
   end

   // Called at a negedge; returns the cycle count seen just after accept.
   task automatic txn(input int u, input bit rd, input bit wr,
                      input logic [9:0] a, input logic [31:0] d,
                      input bit hold, input bit scr, output int acc);
      int   n;
      int   lat;
      exp_t e;
      lat = (u == 0) ? 4 : 1;
      n = 0;
      while (busy[u] && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (busy[u]) check("idle_wait", 32'(busy[u]), 0);
      req_rd[u] = rd;
      req_wr[u] = wr;
      addr[u]   = a;
      wdat[u]   = d;
      @(posedge clk);
      #1;
      acc = ec;
      if (rd) begin
         for (int b = 0; b < 4; b++) begin
            e.ec    = acc + lat - 1 + b;
            e.valid = 1'b1;
            e.idx   = 2'(b);
            e.data  = model[u][{a[9:4], 2'(b)}];
            e.done  = (b == 3);
            push(u, e);
         end
      end else begin
         e.ec    = acc + lat - 1;
         e.valid = 1'b0;
         e.idx   = 2'd0;
         e.data  = 32'd0;
         e.done  = 1'b1;
         push(u, e);
         model[u][a[9:2]] = d;
      end
      if (scr) begin
         @(negedge clk);
         addr[u] = a ^ 10'h3FC;
         wdat[u] = ~d;
      end
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done[u] && n < 40);
      if (!done[u]) check("done_timeout", 32'(done[u]), 1);
      if (!hold) begin
         req_rd[u] = 1'b0;
         req_wr[u] = 1'b0;
      end
      @(negedge clk);
      check("rest_busy", 32'(busy[u]), 1);
      @(negedge clk);
      check("idle_busy", 32'(busy[u]), 0);
   endtask

   task automatic wr(input int u, input logic [9:0] a, input logic [31:0] d);
      int acc;
      txn(u, 1'b0, 1'b1, a, d, 1'b0, 1'b0, acc);
   endtask

   task automatic rd(input int u, input logic [9:0] a);
      int acc;
      txn(u, 1'b1, 1'b0, a, 32'd0, 1'b0, 1'b0, acc);
   endtask

   initial begin
      int acc;
      int a1;
      int a2;
      rst = 1'b1;
      for (int u = 0; u < 2; u++) begin
         req_rd[u] = 1'b0;
         req_wr[u] = 1'b0;
         addr[u]   = '0;
         wdat[u]   = '0;
      end
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy[0]), 0);
      check("rst_rvalid", 32'(rvalid[0]), 0);
      check("rst_done", 32'(done[0]), 0);
      check("rst_out", rdata[0] | 32'(bidx[0]), 0);
      rst = 1'b0;
      mon_en = 1'b1;
      @(negedge clk);

      // Block 0x28, low address bits set to show they are ignored.
      for (int i = 0; i < 4; i++)
         wr(0, {6'h0A, 2'(i), 2'(i)}, $urandom);
      rd(0, 10'h0A4);

      wr(0, 10'h013, 32'hDEADBEEF);
      for (int i = 1; i < 4; i++)
         wr(0, {6'h01, 2'(i), 2'b00}, $urandom);
      rd(0, 10'h010);

      // Both requests: read wins, storage keeps old word 0x2A.
      txn(0, 1'b1, 1'b1, 10'h0A8, 32'h12345678, 1'b0, 1'b0, acc);
      rd(0, 10'h0A0);

      // Inputs scrambled after accept must not reach storage.
      for (int i = 0; i < 4; i++) begin
         wr(0, {6'h04, 2'(i), 2'b00}, $urandom);
         wr(0, {6'h3B, 2'(i), 2'b00}, $urandom);
      end
      txn(0, 1'b0, 1'b1, 10'h044, 32'hCAFEF00D, 1'b0, 1'b1, acc);
      rd(0, 10'h040);
      rd(0, 10'h3B0);

      // Reset in cycle 2 of a write to 0x020.
      for (int i = 0; i < 4; i++)
         wr(0, {6'h02, 2'(i), 2'b00}, $urandom);
      req_wr[0] = 1'b1;
      addr[0]   = 10'h020;
      wdat[0]   = 32'hBAD0BAD0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #2;
      check("wr_busy", 32'(busy[0]), 1);
      rst = 1'b1;
      #1;
      check("arst_busy", 32'(busy[0]), 0);
      check("arst_rvalid", 32'(rvalid[0]), 0);
      check("arst_done", 32'(done[0]), 0);
      check("arst_out", rdata[0] | 32'(bidx[0]), 0);
      req_wr[0] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rd(0, 10'h020);

      // LATENCY=1 instance, request held across done.
      for (int i = 0; i < 4; i++)
         wr(1, {6'h0C, 2'(i), 2'b00}, $urandom);
      txn(1, 1'b1, 1'b0, 10'h0C8, 32'd0, 1'b1, 1'b0, a1);
      txn(1, 1'b1, 1'b0, 10'h0C8, 32'd0, 1'b0, 1'b0, a2);
      check("reaccept_gap", 32'(a2 - a1), 6);

      repeat (2) @(negedge clk);
      check("sb0_empty", 32'(q0.size()), 0);
      check("sb1_empty", 32'(q1.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
